// File: rtl/cpu_pkg.sv
// Shared definitions for the execution sequencer and its register file.
// Opcodes, FSM states and the datapath width must agree with the ula ALU.
package cpu_pkg;

    localparam int LARGURA  = 16;
    localparam int NUM_REGS = 8;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WRITE  = 2'd3
    } estado_t;

    // CLEAR and DISPLAY are resolved locally; every other opcode goes through the ALU.
    function automatic logic usa_ula(input logic [2:0] op);
        return (op != OP_CLEAR) && (op != OP_DISPLAY);
    endfunction

endpackage

// File: rtl/controle_execucao_banco_registradores.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port
// and a synchronous clear-all that takes priority over the write.
module banco_registradores
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         raddr1,
    input  logic [2:0]         raddr2,
    output logic [LARGURA-1:0] rdata1,
    output logic [LARGURA-1:0] rdata2,
    input  logic               we,
    input  logic [2:0]         waddr,
    input  logic [LARGURA-1:0] wdata,
    input  logic               clear
);

    logic [LARGURA-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/controle_execucao.sv
// Instruction sequencer in front of the ula ALU: IDLE -> DECODE -> (EXEC) -> WRITE.
// Defining CTRL_OVERFLOW_FLAG_EN adds a sticky signed-overflow output.
module controle_execucao
    import cpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    output logic [2:0]                ula_opcode,
    output logic signed [LARGURA-1:0] ula_valor1,
    output logic signed [LARGURA-1:0] ula_valor2,
    input  logic signed [LARGURA-1:0] ula_resultado,
    input  logic                      ula_executou,
    output logic [LARGURA-1:0]        saida,
    output logic                      saida_valida,
    output logic                      concluido,
    output logic                      erro
`ifdef CTRL_OVERFLOW_FLAG_EN
    ,
    output logic                      overflow
`endif
);

    estado_t estado, proximo;

    logic [15:0]               instr_q;
    logic [2:0]                opcode, rd, rs1, rs2;
    logic [LARGURA-1:0]        imm7, imm10;
    logic [LARGURA-1:0]        rdata1, rdata2;
    logic [LARGURA-1:0]        op_v1, op_v2;
    logic [LARGURA-1:0]        resultado_q;
    logic                      executou_q;
    logic                      we, clear;

    assign opcode = instr_q[15:13];
    assign rd     = instr_q[12:10];
    assign rs1    = instr_q[9:7];
    assign rs2    = instr_q[6:4];
    assign imm7   = {{9{instr_q[6]}}, instr_q[6:0]};
    assign imm10  = {{6{instr_q[9]}}, instr_q[9:0]};

    assign instr_ready = (estado == IDLE) && rst_n;

    banco_registradores u_banco (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (rd),
        .wdata  (resultado_q),
        .clear  (clear)
    );

    assign we    = (estado == WRITE) && usa_ula(opcode) && executou_q;
    assign clear = (estado == WRITE) && (opcode == OP_CLEAR);

    always_comb begin
        op_v1 = rdata1;
        op_v2 = rdata2;
        case (opcode)
            OP_LOAD:           begin op_v1 = '0; op_v2 = imm10; end
            OP_ADDI, OP_SUBI:  op_v2 = imm7;
            default:           ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            IDLE:    if (instr_valid) proximo = DECODE;
            DECODE:  proximo = usa_ula(opcode) ? EXEC : WRITE;
            EXEC:    proximo = WRITE;
            WRITE:   proximo = IDLE;
            default: proximo = IDLE;
        endcase
    end

    // ALU inputs only change in DECODE of an ALU op, so they hold their last values elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q      <= '0;
            ula_opcode   <= '0;
            ula_valor1   <= '0;
            ula_valor2   <= '0;
            resultado_q  <= '0;
            executou_q   <= 1'b0;
            saida        <= '0;
            saida_valida <= 1'b0;
            concluido    <= 1'b0;
            erro         <= 1'b0;
        end else begin
            saida_valida <= 1'b0;
            concluido    <= 1'b0;
            case (estado)
                IDLE: if (instr_valid) instr_q <= instr;
                DECODE: begin
                    if (usa_ula(opcode)) begin
                        ula_opcode <= opcode;
                        ula_valor1 <= op_v1;
                        ula_valor2 <= op_v2;
                    end
                end
                EXEC: begin
                    resultado_q <= ula_resultado;
                    executou_q  <= ula_executou;
                end
                WRITE: begin
                    concluido <= 1'b1;
                    if (opcode == OP_DISPLAY) begin
                        saida        <= rdata1;
                        saida_valida <= 1'b1;
                    end
                    if (usa_ula(opcode) && !executou_q) erro <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_OVERFLOW_FLAG_EN
    logic signed [16:0] soma17;
    logic signed [31:0] prod32;
    logic               excede;

    // Recompute the true result at full width from the latched operands.
    always_comb begin
        soma17 = 17'(ula_valor1) + 17'(ula_valor2);
        if ((opcode == OP_SUB) || (opcode == OP_SUBI))
            soma17 = 17'(ula_valor1) - 17'(ula_valor2);
        prod32 = 32'(ula_valor1) * 32'(ula_valor2);
        excede = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: excede = soma17[16] != soma17[15];
            OP_MUL:                           excede = prod32[31:15] != {17{prod32[15]}};
            default:                          excede = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if ((estado == WRITE) && executou_q && excede)
            overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_controle_execucao.sv
// Self-checking bench for controle_execucao: ALU stub plus an instruction-level
// reference model of the register file, erro/overflow flags and DISPLAY output.
module tb_controle_execucao;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [2:0]         ula_opcode;
    logic signed [15:0] ula_valor1, ula_valor2, ula_resultado;
    logic               ula_executou;
    logic [15:0]        saida;
    logic               saida_valida, concluido, erro;
`ifdef CTRL_OVERFLOW_FLAG_EN
    logic               overflow;
`endif

    bit force_fail;
    int errors = 0;
    int checks = 0;
    int ref_regs [8];
    bit ref_erro;
    bit ref_ovf;

    controle_execucao dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .ula_opcode    (ula_opcode),
        .ula_valor1    (ula_valor1),
        .ula_valor2    (ula_valor2),
        .ula_resultado (ula_resultado),
        .ula_executou  (ula_executou),
        .saida         (saida),
        .saida_valida  (saida_valida),
        .concluido     (concluido),
        .erro          (erro)
`ifdef CTRL_OVERFLOW_FLAG_EN
        ,
        .overflow      (overflow)
`endif
    );

    always #5 clk = ~clk;

    // Combinational ALU stub; executou can be forced low to exercise erro.
    always_comb begin
        ula_executou = !force_fail;
        case (ula_opcode)
            3'b000:         ula_resultado = ula_valor1 + ula_valor2;
            3'b001, 3'b010: ula_resultado = ula_valor1 + ula_valor2;
            3'b011, 3'b100: ula_resultado = ula_valor1 - ula_valor2;
            3'b101:         ula_resultado = ula_valor1 * ula_valor2;
            default:        ula_resultado = '0;
        endcase
    end

    function automatic int wrap16(input longint v);
        longint m;
        m = v % 65536;
        if (m < 0) m += 65536;
        if (m >= 32768) m -= 65536;
        return int'(m);
    endfunction

    function automatic logic [15:0] mk(input logic [2:0] op, input int rd, input int rs1, input int rs2);
        return {op, 3'(rd), 3'(rs1), 3'(rs2), 4'b0000};
    endfunction

    function automatic logic [15:0] mk_imm(input logic [2:0] op, input int rd, input int rs1, input int imm);
        return {op, 3'(rd), 3'(rs1), 7'(imm)};
    endfunction

    function automatic logic [15:0] mk_load(input int rd, input int imm);
        return {3'b000, 3'(rd), 10'(imm)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        ref_erro = 1'b0;
        ref_ovf  = 1'b0;
    endtask

    // Issues one instruction, checks handshake, latency, ALU drive and retirement effects.
    task automatic issue(input logic [15:0] ins, input bit hold_valid);
        logic [2:0]         op;
        int                 rd, rs1, rs2, imm7, imm10, ev1, ev2, lat, explat;
        longint             t;
        bit                 alu;
        logic [2:0]         got_op;
        logic signed [15:0] got_v1, got_v2;
        logic [15:0]        exp_saida;

        op    = ins[15:13];
        rd    = int'(ins[12:10]);
        rs1   = int'(ins[9:7]);
        rs2   = int'(ins[6:4]);
        imm7  = int'(ins[6:0]);
        if (imm7 >= 64) imm7 -= 128;
        imm10 = int'(ins[9:0]);
        if (imm10 >= 512) imm10 -= 1024;
        alu = (op <= 3'd5);
        ev1 = 0; ev2 = 0; t = 0;
        case (op)
            3'd0: begin ev1 = 0;             ev2 = imm10;         t = longint'(imm10); end
            3'd1: begin ev1 = ref_regs[rs1]; ev2 = ref_regs[rs2]; t = longint'(ev1) + longint'(ev2); end
            3'd2: begin ev1 = ref_regs[rs1]; ev2 = imm7;          t = longint'(ev1) + longint'(ev2); end
            3'd3: begin ev1 = ref_regs[rs1]; ev2 = ref_regs[rs2]; t = longint'(ev1) - longint'(ev2); end
            3'd4: begin ev1 = ref_regs[rs1]; ev2 = imm7;          t = longint'(ev1) - longint'(ev2); end
            3'd5: begin ev1 = ref_regs[rs1]; ev2 = ref_regs[rs2]; t = longint'(ev1) * longint'(ev2); end
            default: ;
        endcase
        explat = alu ? 3 : 2;
        got_op = '0; got_v1 = '0; got_v2 = '0; lat = 0;

        @(negedge clk);
        for (int w = 0; w < 8 && instr_ready !== 1'b1; w++) @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_before_issue: got %b expected 1", instr_ready);
        end
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        if (hold_valid) instr = 16'hC000;
        else            instr_valid = 1'b0;

        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1 && alu) begin
                got_op = ula_opcode;
                got_v1 = ula_valor1;
                got_v2 = ula_valor2;
            end
            if (concluido === 1'b1) begin
                lat = k;
                break;
            end
            checks++;
            if (instr_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_ready (instr %h cycle %0d): got %b expected 0", ins, k, instr_ready);
            end
        end
        instr_valid = 1'b0;

        checks++;
        if (lat !== explat) begin
            errors++;
            $display("[TB] FAIL latency (instr %h): got %0d expected %0d", ins, lat, explat);
        end
        if (alu) begin
            checks++;
            if (got_op !== op) begin
                errors++;
                $display("[TB] FAIL ula_opcode (instr %h): got %0d expected %0d", ins, got_op, op);
            end
            checks++;
            if (int'(got_v1) !== ev1) begin
                errors++;
                $display("[TB] FAIL ula_valor1 (instr %h): got %0d expected %0d", ins, got_v1, ev1);
            end
            checks++;
            if (int'(got_v2) !== ev2) begin
                errors++;
                $display("[TB] FAIL ula_valor2 (instr %h): got %0d expected %0d", ins, got_v2, ev2);
            end
        end

        exp_saida = '0;
        if (alu) begin
            if (force_fail) begin
                ref_erro = 1'b1;
            end else begin
                ref_regs[rd] = wrap16(t);
                if (op != 3'd0 && (t < -32768 || t > 32767)) ref_ovf = 1'b1;
            end
        end else if (op == 3'd6) begin
            for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        end else begin
            exp_saida = 16'(ref_regs[rs1]);
        end

        checks++;
        if (saida_valida !== (op == 3'd7)) begin
            errors++;
            $display("[TB] FAIL saida_valida (instr %h): got %b expected %b", ins, saida_valida, op == 3'd7);
        end
        if (op == 3'd7) begin
            checks++;
            if (saida !== exp_saida) begin
                errors++;
                $display("[TB] FAIL saida (instr %h): got %0d expected %0d", ins, $signed(saida), $signed(exp_saida));
            end
        end
        checks++;
        if (erro !== ref_erro) begin
            errors++;
            $display("[TB] FAIL erro (instr %h): got %b expected %b", ins, erro, ref_erro);
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_retire (instr %h): got %b expected 1", ins, instr_ready);
        end
`ifdef CTRL_OVERFLOW_FLAG_EN
        checks++;
        if (overflow !== ref_ovf) begin
            errors++;
            $display("[TB] FAIL overflow (instr %h): got %b expected %b", ins, overflow, ref_ovf);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        force_fail  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({instr_ready, saida_valida, concluido, erro} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {instr_ready, saida_valida, concluido, erro});
        end
        checks++;
        if ({ula_opcode, ula_valor1, ula_valor2, saida} !== 51'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {ula_opcode, ula_valor1, ula_valor2, saida});
        end
`ifdef CTRL_OVERFLOW_FLAG_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", instr_ready);
        end
        model_reset();
    endtask

    task automatic test_load();
        issue(16'h0405, 1'b0);
        issue(mk(3'd7, 0, 1, 0), 1'b0);
    endtask

    task automatic test_sub_display();
        issue(mk_load(1, 7), 1'b0);
        issue(mk_load(2, -3), 1'b0);
        issue(mk(3'd3, 3, 1, 2), 1'b0);
        issue(mk(3'd7, 0, 3, 0), 1'b0);
        checks++;
        if (saida !== 16'd10) begin
            errors++;
            $display("[TB] FAIL sub_display_value: got %0d expected 10", saida);
        end
    endtask

    task automatic test_mul();
        issue(mk_load(1, 300), 1'b0);
        issue(mk(3'd5, 2, 1, 1), 1'b0);
        issue(mk(3'd7, 0, 2, 0), 1'b0);
        checks++;
        if (saida !== 16'd24464) begin
            errors++;
            $display("[TB] FAIL mul_wrap_value: got %0d expected 24464", saida);
        end
    endtask

    task automatic test_clear();
        for (int r = 0; r < 8; r++) issue(mk_load(r, int'($urandom_range(1, 500))), 1'b0);
        issue(mk(3'd6, 0, 0, 0), 1'b0);
        for (int r = 0; r < 8; r++) issue(mk(3'd7, 0, r, 0), 1'b0);
    endtask

    task automatic test_erro();
        issue(mk_load(4, 11), 1'b0);
        issue(mk_load(5, 2), 1'b0);
        issue(mk_load(6, 3), 1'b0);
        force_fail = 1'b1;
        issue(mk(3'd1, 4, 5, 6), 1'b0);
        force_fail = 1'b0;
        issue(mk(3'd7, 0, 4, 0), 1'b0);
        issue(mk_imm(3'd2, 5, 5, 4), 1'b0);
        issue(mk(3'd7, 0, 5, 0), 1'b0);
    endtask

    task automatic test_back_to_back();
        issue(mk_load(1, -200), 1'b1);
        issue(mk_imm(3'd4, 1, 1, -60), 1'b1);
        issue(mk(3'd1, 3, 1, 1), 1'b1);
        issue(mk(3'd7, 0, 3, 0), 1'b1);
        issue(mk(3'd7, 0, 1, 0), 1'b1);
    endtask

    task automatic test_reset_mid_exec();
        issue(mk_load(1, 9), 1'b0);
        @(negedge clk);
        instr       = mk(3'd1, 2, 1, 1);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ula_opcode !== 3'd1) begin
            errors++;
            $display("[TB] FAIL mid_reset_exec_reached: got %0d expected 1", ula_opcode);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({concluido, instr_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %b expected 00", {concluido, instr_ready});
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (concluido !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_reset_no_concluido: got %b expected 0", concluido);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_release_ready: got %b expected 1", instr_ready);
        end
        issue(mk(3'd7, 0, 1, 0), 1'b0);
        issue(mk(3'd7, 0, 2, 0), 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int n = 0; n < 80; n++) begin
            ins = 16'($urandom);
            issue(ins, 1'($urandom_range(0, 1)));
            issue(mk(3'd7, 0, int'($urandom_range(0, 7)), 0), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_sub_display();
        test_mul();
        test_clear();
        test_erro();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
